hci_prio_arbiter: RTL



---
 rtl/hci_prio_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/hci_prio_arbiter.sv
// Two-to-one TCDM arbiter (HWPE vs core) onto one bank port, with one-cycle response routing.
// Optional starvation guard on the low-priority side: define HCI_PRIO_ARB_STARVATION_GUARD_EN.

package hci_prio_arbiter_pkg;

    typedef struct packed {
        logic [1:0] arb_policy;
        logic       hwpe_prio;
        logic [7:0] low_prio_max_stall;
    } hci_interconnect_ctrl_t;

    typedef enum logic {
        SIDE_HWPE = 1'b0,
        SIDE_CORE = 1'b1
    } side_e;

endpackage

module hci_prio_arbiter
    import hci_prio_arbiter_pkg::*;
#(
    parameter  int unsigned DW = 32,
    parameter  int unsigned AW = 32,
    localparam int unsigned BW = DW / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  hci_interconnect_ctrl_t ctrl_i,

    input  logic                   hwpe_req_i,
    output logic                   hwpe_gnt_o,
    input  logic [AW-1:0]          hwpe_add_i,
    input  logic                   hwpe_wen_i,
    input  logic [BW-1:0]          hwpe_be_i,
    input  logic [DW-1:0]          hwpe_data_i,
    output logic                   hwpe_r_valid_o,
    output logic [DW-1:0]          hwpe_r_data_o,

    input  logic                   core_req_i,
    output logic                   core_gnt_o,
    input  logic [AW-1:0]          core_add_i,
    input  logic                   core_wen_i,
    input  logic [BW-1:0]          core_be_i,
    input  logic [DW-1:0]          core_data_i,
    output logic                   core_r_valid_o,
    output logic [DW-1:0]          core_r_data_o,

    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AW-1:0]          mem_add_o,
    output logic                   mem_wen_o,
    output logic [BW-1:0]          mem_be_o,
    output logic [DW-1:0]          mem_data_o,
    input  logic                   mem_r_valid_i,
    input  logic [DW-1:0]          mem_r_data_i
);

    side_e hp_side;
    side_e lp_side;
    side_e winner;
    side_e rr_q;
    side_e src_q;
    logic  pend_q;

    logic  hp_req;
    logic  lp_req;
    logic  hp_hs;
    logic  lp_hs;
    logic  any_hs;
    logic  win_hwpe;
    logic  lp_overdue;
    logic  resp_ok;

    assign hp_side = ctrl_i.hwpe_prio ? SIDE_HWPE : SIDE_CORE;
    assign lp_side = ctrl_i.hwpe_prio ? SIDE_CORE : SIDE_HWPE;
    assign hp_req  = ctrl_i.hwpe_prio ? hwpe_req_i : core_req_i;
    assign lp_req  = ctrl_i.hwpe_prio ? core_req_i : hwpe_req_i;

`ifdef HCI_PRIO_ARB_STARVATION_GUARD_EN
    logic [7:0] stall_cnt_q;

    assign lp_overdue = (stall_cnt_q >= ctrl_i.low_prio_max_stall);

    // Counts high-priority wins while the low side waits; runs under every policy
    // so a policy switch inherits the current starvation history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 8'd0;
        end else if (clear_i) begin
            stall_cnt_q <= 8'd0;
        end else if (lp_hs || !lp_req) begin
            stall_cnt_q <= 8'd0;
        end else if (hp_hs && (stall_cnt_q != 8'hff)) begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
        end
    end
`else
    logic unused_stall_cfg;

    assign lp_overdue       = 1'b0;
    assign unused_stall_cfg = ^ctrl_i.low_prio_max_stall;
`endif

    // Winner never depends on mem_gnt_i, so the request path stays free of gnt loops.
    always_comb begin
        winner = SIDE_HWPE;
        if (hwpe_req_i && !core_req_i) begin
            winner = SIDE_HWPE;
        end else if (core_req_i && !hwpe_req_i) begin
            winner = SIDE_CORE;
        end else if (hwpe_req_i && core_req_i) begin
            case (ctrl_i.arb_policy)
                2'b01:   winner = rr_q;
                2'b10:   winner = hp_side;
                default: winner = lp_overdue ? lp_side : hp_side;
            endcase
        end
    end

    assign win_hwpe   = (winner == SIDE_HWPE);
    assign hwpe_gnt_o = mem_gnt_i & hwpe_req_i & win_hwpe;
    assign core_gnt_o = mem_gnt_i & core_req_i & ~win_hwpe;
    assign any_hs     = hwpe_gnt_o | core_gnt_o;
    assign hp_hs      = (hp_side == SIDE_HWPE) ? hwpe_gnt_o : core_gnt_o;
    assign lp_hs      = (lp_side == SIDE_HWPE) ? hwpe_gnt_o : core_gnt_o;

    assign mem_req_o  = hwpe_req_i | core_req_i;
    assign mem_add_o  = win_hwpe ? hwpe_add_i  : core_add_i;
    assign mem_wen_o  = win_hwpe ? hwpe_wen_i  : core_wen_i;
    assign mem_be_o   = win_hwpe ? hwpe_be_i   : core_be_i;
    assign mem_data_o = win_hwpe ? hwpe_data_i : core_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= SIDE_HWPE;
            src_q  <= SIDE_HWPE;
            pend_q <= 1'b0;
        end else if (clear_i) begin
            rr_q   <= SIDE_HWPE;
            src_q  <= SIDE_HWPE;
            pend_q <= 1'b0;
        end else begin
            pend_q <= any_hs;
            if (any_hs) begin
                src_q <= winner;
                rr_q  <= win_hwpe ? SIDE_CORE : SIDE_HWPE;
            end
        end
    end

    // A clear in the response cycle discards the response it would have routed.
    assign resp_ok        = mem_r_valid_i & pend_q & ~clear_i;
    assign hwpe_r_valid_o = resp_ok & (src_q == SIDE_HWPE);
    assign core_r_valid_o = resp_ok & (src_q == SIDE_CORE);
    assign hwpe_r_data_o  = mem_r_data_i;
    assign core_r_data_o  = mem_r_data_i;

endmodule
